// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by the fetch FSM top and its instruction buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO buffering fetched words with their PCs.
// Head is read straight from registered storage; clear beats push.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push & ~full;
    assign doPop    = pop & ~empty;
    assign headData = mem[rdPtr];

    // Storage needs no reset: it is only visible through a non-empty head.
    always_ff @(posedge clk) begin
        if (doPush && !clear) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem
// requests, wrong-path flush and a buffer feeding decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            pc_src,
    input  logic [XLEN-1:0] branch_target
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = 32 + XLEN;

    fetch_state_t    state;
    fetch_state_t    nextState;
    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] flushAddr;
    logic [XLEN-1:0] flushNext;
    logic [XLEN-1:0] target;

    logic            ackDone;
    logic            redirect;
    logic            pushEn;
    logic            popEn;
    logic [EW-1:0]   headData;
    logic [EW-1:0]   lastHead;
    logic            fifoFull;
    logic            fifoEmpty;
    logic [CW-1:0]   fifoCount;
    logic [2:0]      unusedBits;

    assign unusedBits = {fifoFull, branch_target[1:0]};
    assign target     = {branch_target[XLEN-1:2], 2'b00};

    assign imem_req  = (state == FLUSH) ||
                       (state == FETCH && fifoCount < CW'(FIFO_DEPTH));
    // In FLUSH the wrong-path address stays on the bus until acked.
    assign imem_addr = (state == FLUSH) ? flushAddr : fetchPc;

    assign ackDone     = imem_req & imem_ack;
    assign instr_valid = ~fifoEmpty;
    assign popEn       = instr_valid & instr_ready;
    assign redirect    = pc_src & popEn;
    assign pushEn      = ackDone & (state == FETCH) & ~redirect;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pushEn),
        .pushData ({imem_rdata, imem_addr}),
        .pop      (popEn),
        .clear    (redirect),
        .headData (headData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    // Keep showing the last presented entry once the buffer drains.
    assign instr    = fifoEmpty ? lastHead[XLEN+:32]    : headData[XLEN+:32];
    assign instr_pc = fifoEmpty ? lastHead[XLEN-1:0] : headData[XLEN-1:0];

    // Remember the most recent head so outputs hold while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastHead <= '0;
        end else if (!fifoEmpty) begin
            lastHead <= headData;
        end
    end

    // State, fetch PC and saved wrong-path address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetchPc   <= RESET_PC;
            flushAddr <= RESET_PC;
        end else begin
            state     <= nextState;
            fetchPc   <= pcNext;
            flushAddr <= flushNext;
        end
    end

    // Next-state, next-PC and flush address selection.
    always_comb begin
        nextState = state;
        pcNext    = fetchPc;
        flushNext = flushAddr;
        unique case (state)
            IDLE: begin
                nextState = FETCH;
            end
            FETCH: begin
                if (redirect) begin
                    pcNext = target;
                    if (imem_req && !imem_ack) begin
                        nextState = FLUSH;
                        flushNext = fetchPc;
                    end
                end else if (ackDone) begin
                    pcNext = fetchPc + XLEN'(INSTR_BYTES);
                end
            end
            FLUSH: begin
                if (redirect) begin
                    pcNext = target;
                end
                if (imem_ack) begin
                    nextState = FETCH;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule
